imem_fetch_arbiter: RTL and testbench
=====================================

IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum number of consecutive fetch grants while debug is waiting.
REQ-002 Parameter BASE_ADDR, default 32'h00400000: byte address of instruction ROM word 0.
REQ-003 Parameter RAM_ADDR_WIDTH, default 9: ROM word-index width (512 words, BASE_ADDR to BASE_ADDR+0x7FF).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 f_req  input  1  fetch-stage read request; held with f_addr until f_gnt.
REQ-007 f_addr  input  32  fetch byte address (PC).
REQ-008 f_gnt  output  1  combinational grant to fetch in the current cycle.
REQ-009 d_req  input  1  debug/loader read request; held with d_addr until d_gnt.
REQ-010 d_addr  input  32  debug byte address.
REQ-011 d_gnt  output  1  combinational grant to debug in the current cycle.
REQ-012 mem_addr  output  32  address driven to the combinational instruction ROM.
REQ-013 mem_inst  input  32  ROM read data, valid in the same cycle as mem_addr.
REQ-014 rdata  output  32  registered read data.
REQ-015 rvalid  output  1  rdata is valid for one cycle.
REQ-016 rowner  output  1  owner of the rdata beat: 0 = fetch, 1 = debug.
REQ-017 rerr  output  1  the returned beat's address was out of range (or misaligned when the check is enabled).

Function
REQ-018 The FSM SHALL have three states: IDLE (no grant last cycle), SRV_F (fetch granted last cycle) and SRV_D (debug granted last cycle); the next state follows the current grant.
REQ-019 Arbitration: at most one grant per cycle; with only one requester, that requester is granted.
REQ-020 With both requesting, fetch SHALL be granted unless the 3-bit streak counter equals STARVE_LIMIT, in which case debug SHALL be granted.
REQ-021 The streak counter SHALL increment on a fetch grant while d_req=1, saturate at STARVE_LIMIT, and clear on any debug grant or any cycle with d_req=0.
REQ-022 mem_addr SHALL equal the granted address, or the previous mem_addr when nothing is granted.
REQ-023 Latency: a grant in cycle N SHALL produce rvalid=1 in cycle N+1, with rdata, rowner and rerr for that request; rvalid=0 in cycle N+1 if there was no grant in N.
REQ-024 Throughput: one grant per cycle, so back-to-back fetches return on consecutive cycles.
REQ-025 Range check: the address is in range if BASE_ADDR <= addr <= BASE_ADDR + 4*2^RAM_ADDR_WIDTH - 1 (32-bit unsigned compare); otherwise rdata=0 and rerr=1 on return, and the grant is still given.
REQ-026 Address wrap: an address at or above BASE_ADDR+0x800, or below BASE_ADDR, SHALL NOT alias onto ROM words.
REQ-027 A grant SHALL be independent of rvalid; no request is dropped or duplicated.

Reset
REQ-028 While reset=0 at a clock edge, the FSM SHALL go to IDLE, the streak counter to 0, and rdata, rvalid, rowner, rerr and mem_addr to 0.
REQ-029 While reset=0, f_gnt and d_gnt SHALL be 0.
REQ-030 A grant issued in the cycle reset is asserted SHALL NOT produce rvalid after reset.

Configuration
REQ-031 Macro IMEM_ALIGN_CHECK_EN: when defined, addr[1:0] != 2'b00 SHALL be treated as an error (rdata=0, rerr=1).
REQ-032 When IMEM_ALIGN_CHECK_EN is not defined, addr[1:0] SHALL be ignored (word-truncated), and rerr reflects the range check only.

Verification
REQ-033 Fetch only, f_addr=0x00400000,0x00400004 in consecutive cycles -> rvalid on both following cycles, rdata = ROM words 0 and 1, rowner=0, rerr=0.
REQ-034 f_req and d_req held with STARVE_LIMIT=4 -> f_gnt for 4 cycles, d_gnt on the 5th, then fetch resumes and the streak counter reads 0.
REQ-035 d_addr=0x00400800 -> d_gnt, next cycle rvalid=1, rowner=1, rerr=1, rdata=0; d_addr=0x003FFFFC gives the same response.
REQ-036 With IMEM_ALIGN_CHECK_EN, f_addr=0x00400002 -> rerr=1, rdata=0; without the macro -> rdata = ROM word 0, rerr=0.
REQ-037 Grant in cycle N with reset=0 at the edge ending N -> no rvalid in N+1, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
// Two-master arbiter (fetch, debug) in front of a combinational instruction ROM, with registered return data.
// Optional IMEM_ALIGN_CHECK_EN: when defined, a misaligned address is returned as an error beat.
module imem_fetch_arbiter #(
    parameter int          STARVE_LIMIT   = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h00400000,
    parameter int          RAM_ADDR_WIDTH = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        rowner,
    output logic        rerr,
    output logic [1:0]  o_dbg_state,
    output logic [2:0]  o_dbg_streak
);

    // Handshake: a request is held with its address until its grant; the grant
    // cycle is the transfer, and the response beat follows exactly one cycle later.

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + (32'd4 << RAM_ADDR_WIDTH) - 32'd1;
    localparam logic [2:0]  LIMIT     = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SRV_F = 2'd1,
        ST_SRV_D = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_streak;
    logic [31:0] r_mem_addr;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_rowner;
    logic        r_rerr;

    logic        w_f_gnt;
    logic        w_d_gnt;
    logic        w_any_gnt;
    logic [31:0] w_addr;
    logic        w_in_range;
    logic        w_err;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: the state records who was granted this cycle
    always_comb begin
        w_next_state = ST_IDLE;
        if (w_d_gnt) begin
            w_next_state = ST_SRV_D;
        end else if (w_f_gnt) begin
            w_next_state = ST_SRV_F;
        end
    end

    // Grant outputs: fetch wins unless debug has waited through LIMIT fetch grants
    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (reset) begin
            if (d_req && (!f_req || r_streak == LIMIT)) begin
                w_d_gnt = 1'b1;
            end else if (f_req) begin
                w_f_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_f_gnt | w_d_gnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_streak <= 3'd0;
        end else if (!d_req || w_d_gnt) begin
            r_streak <= 3'd0;
        end else if (w_f_gnt && r_streak != LIMIT) begin
            r_streak <= r_streak + 3'd1;
        end
    end

    always_comb begin
        w_addr = r_mem_addr;
        if (w_d_gnt) begin
            w_addr = d_addr;
        end else if (w_f_gnt) begin
            w_addr = f_addr;
        end
    end

    // Full 32-bit compare so out-of-window addresses never alias onto ROM words
    assign w_in_range = (w_addr >= BASE_ADDR) && (w_addr <= LAST_ADDR);

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_err = !w_in_range || (w_addr[1:0] != 2'b00);
`else
    assign w_err = !w_in_range;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_addr <= 32'd0;
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_rowner   <= 1'b0;
            r_rerr     <= 1'b0;
        end else begin
            r_mem_addr <= w_addr;
            r_rvalid   <= w_any_gnt;
            if (w_any_gnt) begin
                r_rdata  <= w_err ? 32'd0 : mem_inst;
                r_rowner <= w_d_gnt;
                r_rerr   <= w_err;
            end
        end
    end

    assign f_gnt        = w_f_gnt;
    assign d_gnt        = w_d_gnt;
    assign mem_addr     = w_addr;
    assign rdata        = r_rdata;
    assign rvalid       = r_rvalid;
    assign rowner       = r_rowner;
    assign rerr         = r_rerr;
    assign o_dbg_state  = r_state;
    assign o_dbg_streak = r_streak;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: vector table plus starvation and reset sequences.
module tb_imem_fetch_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rowner;
    logic        rerr;
    logic [1:0]  o_dbg_state;
    logic [2:0]  o_dbg_streak;

    int checks;
    int failures;

    imem_fetch_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_gnt        (f_gnt),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_gnt        (d_gnt),
        .mem_addr     (mem_addr),
        .mem_inst     (mem_inst),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rowner       (rowner),
        .rerr         (rerr),
        .o_dbg_state  (o_dbg_state),
        .o_dbg_streak (o_dbg_streak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: distinct word per 9-bit index
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [8:0] idx;
        idx = a[10:2];
        return 32'hA5000000 | {19'd0, idx, 4'h3};
    endfunction

    assign mem_inst = rom_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        exp_f_gnt;
        logic        exp_d_gnt;
        logic [31:0] exp_mem_addr;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_rowner;
        logic        exp_rerr;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[9];

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 32'h00400000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00400000,
                    1'b1, rom_word(32'h00400000), 1'b0, 1'b0, 2'd1};
        vecs[2] = '{1'b1, 32'h00400004, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00400004,
                    1'b1, rom_word(32'h00400004), 1'b0, 1'b0, 2'd1};
        vecs[3] = '{1'b0, 32'h00400100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00400004,
                    1'b0, rom_word(32'h00400004), 1'b0, 1'b0, 2'd0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h00400800, 1'b0, 1'b1, 32'h00400800,
                    1'b1, 32'h0, 1'b1, 1'b1, 2'd2};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h003FFFFC, 1'b0, 1'b1, 32'h003FFFFC,
                    1'b1, 32'h0, 1'b1, 1'b1, 2'd2};
        vecs[6] = '{1'b1, 32'h004007FC, 1'b0, 32'h0, 1'b1, 1'b0, 32'h004007FC,
                    1'b1, 32'hA5001FF3, 1'b0, 1'b0, 2'd1};
`ifdef IMEM_ALIGN_CHECK_EN
        vecs[7] = '{1'b1, 32'h00400002, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00400002,
                    1'b1, 32'h0, 1'b0, 1'b1, 2'd1};
`else
        vecs[7] = '{1'b1, 32'h00400002, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00400002,
                    1'b1, 32'hA5000003, 1'b0, 1'b0, 2'd1};
`endif
        vecs[8] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFC,
                    1'b1, 32'h0, 1'b0, 1'b1, 2'd1};

        // Reset with a request pending: no grants, all outputs cleared
        reset  = 1'b0;
        f_req  = 1'b1;
        f_addr = 32'h00400010;
        d_req  = 1'b1;
        d_addr = 32'h00400020;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_f_gnt", 32'(f_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rowner", 32'(rowner), 32'd0);
        chk("rst_rerr", 32'(rerr), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        chk("rst_streak", 32'(o_dbg_streak), 32'd0);
        f_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b1;

        // Table: one vector per cycle, grants before the edge, response after
        for (int i = 0; i < 9; i++) begin
            f_req  = vecs[i].f_req;
            f_addr = vecs[i].f_addr;
            d_req  = vecs[i].d_req;
            d_addr = vecs[i].d_addr;
            #1;
            chk($sformatf("v%0d_f_gnt", i), 32'(f_gnt), 32'(vecs[i].exp_f_gnt));
            chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].exp_d_gnt));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_mem_addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
            chk($sformatf("v%0d_state", i), 32'(o_dbg_state), 32'(vecs[i].exp_state));
            if (vecs[i].exp_rvalid) begin
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
                chk($sformatf("v%0d_rowner", i), 32'(rowner), 32'(vecs[i].exp_rowner));
                chk($sformatf("v%0d_rerr", i), 32'(rerr), 32'(vecs[i].exp_rerr));
            end
        end

        // Starvation: both held; 4 fetch grants, 1 debug grant, then fetch again
        f_req  = 1'b1;
        f_addr = 32'h00400010;
        d_req  = 1'b1;
        d_addr = 32'h00400020;
        for (int k = 0; k < 7; k++) begin
            logic       exp_d;
            logic [2:0] exp_streak;
            exp_d      = (k == 4);
            exp_streak = (k < 4) ? 3'(k + 1) : (k == 4) ? 3'd0 : 3'(k - 4);
            #1;
            chk($sformatf("starve%0d_f_gnt", k), 32'(f_gnt), 32'(!exp_d));
            chk($sformatf("starve%0d_d_gnt", k), 32'(d_gnt), 32'(exp_d));
            @(posedge clk);
            #1;
            chk($sformatf("starve%0d_streak", k), 32'(o_dbg_streak), 32'(exp_streak));
            chk($sformatf("starve%0d_rowner", k), 32'(rowner), 32'(exp_d));
            chk($sformatf("starve%0d_rdata", k), rdata,
                exp_d ? rom_word(32'h00400020) : rom_word(32'h00400010));
        end
        // Dropping d_req clears the streak
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("streak_clear", 32'(o_dbg_streak), 32'd0);

        // Debug grant leaves rowner=1 and nonzero rdata; then reset lands on the next grant
        f_req  = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h00400040;
        @(posedge clk);
        #1;
        chk("pre_rst_rowner", 32'(rowner), 32'd1);
        chk("pre_rst_rdata", rdata, rom_word(32'h00400040));
        d_req  = 1'b0;
        f_req  = 1'b1;
        f_addr = 32'h00400008;
        reset  = 1'b0;
        #1;
        chk("rst_hold_f_gnt", 32'(f_gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_rowner", 32'(rowner), 32'd0);
        chk("post_rst_rerr", 32'(rerr), 32'd0);
        chk("post_rst_mem_addr", mem_addr, 32'd0);
        chk("post_rst_state", 32'(o_dbg_state), 32'd0);
        reset = 1'b1;
        #1;
        chk("after_rst_f_gnt", 32'(f_gnt), 32'd1);
        @(posedge clk);
        #1;
        chk("after_rst_rvalid", 32'(rvalid), 32'd1);
        chk("after_rst_rdata", rdata, rom_word(32'h00400008));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
